// File: rtl/shift_pkg.sv
// Shared types and encodings for the shift issue stage and its decoder.
// The shift_type_t encoding matches the execute-stage barrel shifter.
package shift_pkg;

  localparam int SHIFT_XLEN = 32;

  typedef enum logic [1:0] {
    SRL = 2'b00,
    SLL = 2'b01,
    SRA = 2'b10
  } shift_type_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } occ_t;

  typedef struct packed {
    logic [SHIFT_XLEN-1:0] a;
    logic [4:0]            shamt;
    shift_type_t           stype;
    logic                  is_shift;
    logic [4:0]            rd;
  } shift_entry_t;

endpackage

// File: rtl/shift_decoder.sv
// Combinational RV32I shift decode: turns an instruction word plus operands
// into the payload the issue stage buffers for the barrel shifter.
module shift_decoder
  import shift_pkg::*;
(
  input  logic [31:0]            instr,
  input  logic [SHIFT_XLEN-1:0]  rs1,
  input  logic [4:0]             rs2_lo,
  output shift_entry_t           entry
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_reg;
  logic       is_imm;

  // The rs1 register index is irrelevant here; the value arrives forwarded.
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^instr[19:15];

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign is_reg = (opcode == OPC_OP);
  assign is_imm = (opcode == OPC_OP_IMM);

  always_comb begin
    entry          = '0;
    entry.a        = rs1;
    entry.rd       = instr[11:7];
    entry.stype    = SRL;
    entry.is_shift = 1'b0;
    if (is_reg || is_imm) begin
      if (funct7 == F7_BASE && funct3 == F3_SLL) begin
        entry.is_shift = 1'b1;
        entry.stype    = SLL;
      end else if (funct7 == F7_BASE && funct3 == F3_SR) begin
        entry.is_shift = 1'b1;
        entry.stype    = SRL;
      end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
        entry.is_shift = 1'b1;
        entry.stype    = SRA;
      end
    end
    // Non-shifts forward a zero shamt so the shifter never sees stale amounts.
    if (entry.is_shift) begin
      entry.shamt = is_reg ? rs2_lo : instr[24:20];
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Registered issue stage feeding the barrel shifter: decodes shifts and
// buffers them in a two-entry skid buffer so in_ready never depends on out_ready.
//
// state | meaning
// EMPTY | no entry held, outputs invalid
// ONE   | main register holds the output entry
// TWO   | main holds the output entry, skid holds the next one; input blocked
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [4:0]      out_shamt,
  output logic [1:0]      out_type,
  output logic            out_is_shift,
  output logic [4:0]      out_rd
);

  occ_t         state_q, state_d;
  shift_entry_t main_q, main_d;
  shift_entry_t skid_q, skid_d;
  shift_entry_t dec_entry;
  logic         in_xfer;
  logic         out_xfer;

  // Only the low five rs2 bits can ever form a shift amount.
  logic unused_rs2_hi;
  assign unused_rs2_hi = ^in_rs2[XLEN-1:5];

  shift_decoder u_decoder (
    .instr  (in_instr),
    .rs1    (in_rs1),
    .rs2_lo (in_rs2[4:0]),
    .entry  (dec_entry)
  );

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = dec_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = dec_entry;
          end else if (in_xfer) begin
            skid_d  = dec_entry;
            state_d = TWO;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_a        = main_q.a;
  assign out_shamt    = main_q.shamt;
  assign out_type     = main_q.stype;
  assign out_is_shift = main_q.is_shift;
  assign out_rd       = main_q.rd;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed and randomized checks of the shift issue stage against
// hand-computed vectors and an independent decode model.
module tb_shift_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [4:0]  out_shamt;
  logic [1:0]  out_type;
  logic        out_is_shift;
  logic [4:0]  out_rd;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  logic [44:0] q[$];
  logic [44:0] held;
  logic        hold_valid;

  shift_issue_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_shamt    (out_shamt),
    .out_type     (out_type),
    .out_is_shift (out_is_shift),
    .out_rd       (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [44:0] obs_entry();
    return {out_a, out_shamt, out_type, out_is_shift, out_rd};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] f24,
                                     input logic [4:0] r1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, f24, r1, f3, rd, op};
  endfunction

  // Reference decode written from the RV32I encodings.
  function automatic logic [44:0] model(input logic [31:0] i, input logic [31:0] r1,
                                        input logic [31:0] r2);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       sh;
    logic [1:0] t;
    logic [4:0] s;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    sh = 1'b0;
    t  = 2'b00;
    s  = 5'd0;
    if (op == 7'h33 || op == 7'h13) begin
      if (f3 == 3'b001 && f7 == 7'h00) begin sh = 1'b1; t = 2'b01; end
      else if (f3 == 3'b101 && f7 == 7'h00) begin sh = 1'b1; t = 2'b00; end
      else if (f3 == 3'b101 && f7 == 7'h20) begin sh = 1'b1; t = 2'b10; end
    end
    if (sh) s = (op == 7'h33) ? r2[4:0] : i[24:20];
    return {r1, s, t, sh, i[11:7]};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 4)
      0: op = 7'h33;
      1, 2: op = 7'h13;
      default: op = r[6:0];
    endcase
    case ($urandom % 3)
      0: f3 = 3'b001;
      1: f3 = 3'b101;
      default: f3 = r[14:12];
    endcase
    case ($urandom % 3)
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:15], f3, r[11:7], op};
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    in_instr = i;
    in_rs1   = r1;
    in_rs2   = r2;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    hold_valid = 1'b0;
    held      = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'(obs_entry()), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Single-entry decodes at full throughput.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(32'h4031D093, 32'h80000010, 32'h0000001F);
    tick();
    check("srai_valid", 64'(out_valid), 64'd1);
    check("srai", 64'(obs_entry()), 64'({32'h80000010, 5'd3, 2'b10, 1'b1, 5'd1}));
    drive(32'h007312B3, 32'h12345678, 32'hFFFFFF25);
    tick();
    check("sll", 64'(obs_entry()), 64'({32'h12345678, 5'd5, 2'b01, 1'b1, 5'd5}));
    drive(32'h003100B3, 32'hDEADBEEF, 32'h00000007);
    tick();
    check("add", 64'(obs_entry()), 64'({32'hDEADBEEF, 5'd0, 2'b00, 1'b0, 5'd1}));
    drive(mk(7'h20, 5'd9, 5'd2, 3'b101, 5'd7, 7'h33), 32'hF0000000, 32'hFFFFFFE9);
    tick();
    check("sra_reg", 64'(obs_entry()), 64'({32'hF0000000, 5'd9, 2'b10, 1'b1, 5'd7}));
    drive(mk(7'h20, 5'd4, 5'd2, 3'b001, 5'd8, 7'h13), 32'h00000055, 32'h0);
    tick();
    check("bad_slli_f7", 64'(obs_entry()), 64'({32'h00000055, 5'd0, 2'b00, 1'b0, 5'd8}));
    in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: out_ready low across three edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(mk(7'h00, 5'd1, 5'd0, 3'b001, 5'd2, 7'h13), 32'hA0, 32'h0);
    tick();
    check("bp_ready_1", 64'(in_ready), 64'd1);
    check("bp_head_0", 64'(out_a), 64'hA0);
    drive(mk(7'h00, 5'd2, 5'd0, 3'b001, 5'd3, 7'h13), 32'hA1, 32'h0);
    tick();
    check("bp_ready_fall", 64'(in_ready), 64'd0);
    check("bp_head_1", 64'(out_a), 64'hA0);
    drive(mk(7'h00, 5'd3, 5'd0, 3'b001, 5'd4, 7'h13), 32'hA2, 32'h0);
    tick();
    check("bp_ready_held", 64'(in_ready), 64'd0);
    check("bp_stable", 64'(obs_entry()), 64'({32'hA0, 5'd1, 2'b01, 1'b1, 5'd2}));
    out_ready = 1'b1;
    tick();
    check("bp_out_1", 64'(out_a), 64'hA1);
    check("bp_valid_1", 64'(out_valid), 64'd1);
    check("bp_ready_rise", 64'(in_ready), 64'd1);
    tick();
    check("bp_out_2", 64'(obs_entry()), 64'({32'hA2, 5'd3, 2'b01, 1'b1, 5'd4}));
    drive(mk(7'h00, 5'd4, 5'd0, 3'b001, 5'd5, 7'h13), 32'hA3, 32'h0);
    tick();
    check("bp_out_3", 64'(out_a), 64'hA3);
    check("bp_valid_3", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Flush from TWO with a concurrent input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(32'h003100B3, 32'hB0, 32'h0);
    tick();
    drive(32'h003100B3, 32'hB1, 32'h0);
    tick();
    check("fl_two", 64'(in_ready), 64'd0);
    drive(32'h003100B3, 32'hB2, 32'h0);
    flush = 1'b1;
    tick();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("fl_no_ghost", 64'(out_valid), 64'd0);
    in_valid = 1'b1;
    drive(32'h003100B3, 32'hC0, 32'h0);
    tick();
    check("fl_recover", 64'(out_a), 64'hC0);
    in_valid = 1'b0;
    tick();

    // Asynchronous reset while holding an entry.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(32'h4031D093, 32'hD0, 32'h0);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", 64'(obs_entry()), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_after", 64'(out_valid), 64'd0);

    // Random handshake traffic against the reference model; last few cycles drain.
    for (int n = 0; n < 10006; n++) begin
      if (n < 10000) begin
        in_valid  = ($urandom % 4) != 0;
        out_ready = ($urandom % 3) != 0;
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      drive(rand_instr(), $urandom, $urandom);
      check("occupancy", 64'({out_valid, in_ready}), 64'({q.size() != 0, q.size() < 2}));
      if (hold_valid) check("hold", 64'(obs_entry()), 64'(held));
      hold_valid = out_valid && !out_ready;
      held       = obs_entry();
      if (out_valid && out_ready && q.size() > 0) begin
        check("order", 64'(obs_entry()), 64'(q.pop_front()));
      end
      if (in_valid && in_ready) q.push_back(model(in_instr, in_rs1, in_rs2));
      tick();
    end
    check("rand_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Registered issue stage directly upstream of the execute-stage barrel shifter in the RISC-V pipelined core. Accepts decoded-stage instruction words plus rs1/rs2 operand values over a valid/ready handshake. Identifies RV32I shift instructions (SLL, SRL, SRA, SLLI, SRLI, SRAI) and produces the shifter's operand `A`, 5-bit `Shamt` and 2-bit `Type`. A two-entry skid buffer provides full throughput under downstream backpressure.

## Interface
- `XLEN`, 32: operand width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  upstream presents an instruction.
- `in_ready`  out  1  stage can accept; registered, not a combinational function of `out_ready`.
- `in_instr`  in  32  instruction word.
- `in_rs1`  in  XLEN  rs1 value, already forwarded.
- `in_rs2`  in  XLEN  rs2 value, already forwarded.
- `flush`  in  1  synchronous pipeline flush; highest priority.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  shifter stage accepts.
- `out_a`  out  XLEN  shifter operand A (= rs1).
- `out_shamt`  out  5  shift amount.
- `out_type`  out  2  00 SRL, 01 SLL, 10 SRA; 11 never emitted.
- `out_is_shift`  out  1  entry is a shift instruction.
- `out_rd`  out  5  destination register, `instr[11:7]`.

## Operation
- Decode:
  - opcode 0110011 with funct7 0000000: funct3 001 -> SLL, funct3 101 -> SRL.
  - opcode 0110011 with funct7 0100000: funct3 101 -> SRA.
  - opcode 0010011 with `instr[31:25]` = 0000000: funct3 001 -> SLLI, funct3 101 -> SRLI.
  - opcode 0010011 with `instr[31:25]` = 0100000: funct3 101 -> SRAI.
- Shamt source: register forms use `in_rs2[4:0]`; immediate forms use `instr[24:20]`. Upper rs2 bits are ignored.
- Non-shift instructions are still accepted and forwarded in order, with `out_is_shift`=0, `out_type`=00 and `out_shamt`=0. `out_a` and `out_rd` are passed through unchanged.
- A transfer occurs on a cycle with valid=1 and ready=1 on that side.
- Buffer: a main register drives the outputs; a skid register catches one entry when the output is blocked.
- Occupancy FSM:
  - EMPTY -> ONE on input transfer.
  - ONE -> ONE on simultaneous input and output transfer.
  - ONE -> TWO on input transfer with no output transfer.
  - ONE -> EMPTY on output transfer only.
  - TWO -> ONE on output transfer; the skid entry moves to main.
  - TWO never accepts input.
- `in_ready` = (state != TWO). `out_valid` = (state != EMPTY).
- Order is strictly FIFO. No entry is duplicated or dropped, except on flush.
- `flush`=1: next state is EMPTY and both entries are discarded. Any input or output transfer in the same cycle is ignored; the input is dropped.
- While `out_valid`=1 and `out_ready`=0, all `out_*` signals are held stable.

## Timing
- Latency is one cycle: an input accepted at edge N is visible on `out_*` after edge N when the buffer was EMPTY, or when it was ONE with a simultaneous output transfer.
- Throughput is one entry per cycle while `out_ready`=1.
- Reset (`rst_n`=0, asynchronous):
  - state EMPTY, `out_valid`=0, `in_ready`=1.
  - all data outputs 0, including `out_type`=00 and `out_is_shift`=0.
- Reset deassertion is honoured at the next clock edge. Reset mid-transfer discards all entries.
- `in_ready` deasserts on the edge that fills the skid register. It reasserts on the edge after the first output transfer out of TWO.

## Structure
- Package `shift_pkg` holds:
  - `shift_type_t` (SRL=2'b00, SLL=2'b01, SRA=2'b10), matching the shifter's encoding.
  - opcode constants `OPC_OP` and `OPC_OP_IMM`.
  - funct3 constants `F3_SLL` and `F3_SR`; funct7 constants `F7_BASE` and `F7_ALT`.
  - occupancy enum `occ_t` (EMPTY, ONE, TWO).
  - packed struct `shift_entry_t` {a, shamt, type, is_shift, rd}.
- Sub-module `shift_decoder`: combinational; maps instr and rs2 to a `shift_entry_t` payload. The top level holds the FSM and the two entry registers.

## Test plan
- Reset state: hold `rst_n`=0 -> `out_valid`=0, `in_ready`=1, all data outputs 0.
- SRAI decode: instr 0x4031D093 (srai x1,x3,3) with rs1=0x80000010 -> next cycle `out_type`=10, `out_shamt`=3, `out_a`=0x80000010, `out_rd`=1, `out_is_shift`=1.
- SLL decode: register SLL with rs2=0xFFFFFF25 -> `out_shamt`=5, `out_type`=01. ADD (0x003100B3) -> `out_is_shift`=0, `out_type`=00.
- Backpressure: stream 4 instructions with `out_ready`=0 for 3 cycles.
  - `in_ready` falls after 2 accepts; outputs stay stable while blocked.
  - After release, all 4 entries emerge in order with no gaps.
- Flush: with the buffer in TWO and `in_valid`=1, pulse `flush` -> next cycle `out_valid`=0 and `in_ready`=1; the flushed-cycle input never appears on the output.
- Random valid/ready toggling, 10k cycles: a scoreboard confirms in-order, lossless delivery and a decode that matches the reference model.
